// File: rtl/fsk_pkg.sv
// fsk_pkg -- shared definitions for the FSK tone path.
//   phase_e        : tone phase state (PH_HIGH drives tone high, PH_LOW drives it low)
//   FSK_CNT_W      : default counter / latched-period width
//   FSK_DEFAULT_PERIOD, FSK_MIN_PERIOD, FSK_MAX_PERIOD : period reset value and clamp limits
//   clamp_period() : saturates a 32-bit period request into [lo, hi]
package fsk_pkg;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    localparam int FSK_CNT_W          = 16;
    localparam int FSK_DEFAULT_PERIOD = 98;
    localparam int FSK_MIN_PERIOD     = 2;
    localparam int FSK_MAX_PERIOD     = 65535;

    // The compare is done on the full 32-bit request so that out-of-range values
    // saturate instead of wrapping when the caller truncates to the counter width.
    function automatic logic [31:0] clamp_period(input logic [31:0] p,
                                                 input logic [31:0] lo,
                                                 input logic [31:0] hi);
        logic [31:0] r;
        r = p;
        if (p < lo) r = lo;
        else if (p > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/fsk_tone_divider.sv
// fsk_tone_divider -- programmable square-wave tone generator.
//   Divides clk by the latched period P: tone_out is high for ceil(P/2) clks, then
//   low for floor(P/2) clks. A new period is latched only at the LOW->HIGH boundary,
//   so the tone never glitches; cycle_tick pulses for one clk on that boundary and
//   steps the upstream period-modulation stage.
// Optional feature macro: FSK_SYMBOL_SEL_EN
//   defined   : symbol_in selects period_alt_in (1) or period_in (0) at the boundary
//   undefined : period_in only; period_alt_in and symbol_in are not ports
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   enable        in   1 = run, 0 = freeze counter/phase/period, suppress tick
//   period_in     in   [31:0] requested period in clks
//   period_alt_in in   [31:0] alternate (space) period       (FSK_SYMBOL_SEL_EN only)
//   symbol_in     in   period select                          (FSK_SYMBOL_SEL_EN only)
//   tone_out      out  square-wave tone
//   cycle_tick    out  registered 1-clk pulse coincident with tone_out rising
//   period_active out  [CNT_W-1:0] period currently being generated (post-clamp)
//   phase_o       out  current phase state, for observation
module fsk_tone_divider
    import fsk_pkg::*;
#(
    parameter int CNT_W          = FSK_CNT_W,
    parameter int DEFAULT_PERIOD = FSK_DEFAULT_PERIOD,
    parameter int MIN_PERIOD     = FSK_MIN_PERIOD,
    parameter int MAX_PERIOD     = FSK_MAX_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [31:0]      period_in,
`ifdef FSK_SYMBOL_SEL_EN
    input  logic [31:0]      period_alt_in,
    input  logic             symbol_in,
`endif
    output logic             tone_out,
    output logic             cycle_tick,
    output logic [CNT_W-1:0] period_active,
    output phase_e           phase_o
);

    localparam logic [CNT_W:0] ONE_W = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    phase_e           phase_q, phase_d;
    logic             tick_q, tick_d;

    logic [CNT_W:0]   half_len;
    logic             half_done;
    logic [31:0]      sel_period;

`ifdef FSK_SYMBOL_SEL_EN
    assign sel_period = symbol_in ? period_alt_in : period_in;
`else
    assign sel_period = period_in;
`endif

    // One extra bit so ceil(P/2) = (P+1)/2 cannot overflow at P = 2**CNT_W-1.
    always_comb begin
        if (phase_q == PH_HIGH) half_len = ({1'b0, period_q} + ONE_W) >> 1;
        else                    half_len = {1'b0, period_q} >> 1;
    end

    // P >= 2 after clamping, so half_len >= 1 and half_len-1 never underflows.
    assign half_done = ({1'b0, cnt_q} == (half_len - ONE_W));

    always_comb begin
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        period_d = period_q;
        tick_d   = 1'b0;
        if (enable) begin
            if (half_done) begin
                cnt_d = '0;
                if (phase_q == PH_LOW) begin
                    phase_d  = PH_HIGH;
                    period_d = CNT_W'(clamp_period(sel_period, 32'(MIN_PERIOD),
                                                   32'(MAX_PERIOD)));
                    tick_d   = 1'b1;
                end else begin
                    phase_d = PH_LOW;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            phase_q  <= PH_LOW;
            period_q <= CNT_W'(DEFAULT_PERIOD);
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    // tone_out is the phase flop itself, so it is a clean registered output.
    assign tone_out      = (phase_q == PH_HIGH);
    assign cycle_tick    = tick_q;
    assign period_active = period_q;
    assign phase_o       = phase_q;

endmodule

// File: tb/tb_fsk_tone_divider.sv
// tb_fsk_tone_divider -- directed checks of fsk_tone_divider.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fsk_tone_divider;
    import fsk_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] period_in;
    logic [31:0] period_alt_in;
    logic        symbol_in;
    logic        tone_out;
    logic        cycle_tick;
    logic [15:0] period_active;
    phase_e      phase_o;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fsk_tone_divider dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .period_in     (period_in),
`ifdef FSK_SYMBOL_SEL_EN
        .period_alt_in (period_alt_in),
        .symbol_in     (symbol_in),
`endif
        .tone_out      (tone_out),
        .cycle_tick    (cycle_tick),
        .period_active (period_active),
        .phase_o       (phase_o)
    );

    // ---------------- driver / check tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Steps until cycle_tick is seen; n = number of clks waited.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (cycle_tick !== 1'b1 && n < 1000);
        if (cycle_tick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no tick after %0d clks", n);
        end
    endtask

    // Called on a tick sample; measures the HIGH and LOW halves of that cycle
    // and ends on the next tick sample.
    task automatic measure(output int hi, output int lo, output int stray);
        hi = 0;
        lo = 0;
        stray = 0;
        while (tone_out === 1'b1 && hi < 1000) begin
            hi++;
            step();
            if (cycle_tick === 1'b1) stray++;
        end
        while (tone_out === 1'b0 && lo < 1000) begin
            lo++;
            step();
            if (tone_out === 1'b0 && cycle_tick === 1'b1) stray++;
        end
    endtask

    typedef struct {
        logic [31:0] per;
        int          pa;
        int          hi;
        int          lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, m, hi, lo, stray;

        vecs[0] = '{per: 32'd98,  pa: 98,  hi: 49, lo: 49};
        vecs[1] = '{per: 32'd99,  pa: 99,  hi: 50, lo: 49};
        vecs[2] = '{per: 32'd0,   pa: 2,   hi: 1,  lo: 1};
        vecs[3] = '{per: 32'd1,   pa: 2,   hi: 1,  lo: 1};
        vecs[4] = '{per: 32'd3,   pa: 3,   hi: 2,  lo: 1};
        vecs[5] = '{per: 32'd120, pa: 120, hi: 60, lo: 60};

        rst_n = 1'b0;
        enable = 1'b1;
        period_in = 32'd98;
        period_alt_in = 32'd0;
        symbol_in = 1'b0;
        repeat (3) step();

        // ---- reset values ----
        check("rst_tone", tone_out, 0);
        check("rst_tick", cycle_tick, 0);
        check("rst_period", period_active, 98);
        check("rst_phase", phase_o, PH_LOW);

        // First half after reset is the LOW half of the default period.
        rst_n = 1'b1;
        wait_tick(n);
        check("first_low_len", n, 49);
        check("first_tone_high", tone_out, 1);

        // ---- table: steady-state cycles per requested period ----
        foreach (vecs[i]) begin
            period_in = vecs[i].per;
            wait_tick(n);
            check($sformatf("v%0d_period_active", i), period_active, vecs[i].pa);
            measure(hi, lo, stray);
            check($sformatf("v%0d_high", i), hi, vecs[i].hi);
            check($sformatf("v%0d_low", i), lo, vecs[i].lo);
            check($sformatf("v%0d_stray_tick", i), stray, 0);
            check($sformatf("v%0d_tick_at_rise", i), cycle_tick, 1);
        end

        // ---- period change mid-HIGH only applies to the next cycle ----
        period_in = 32'd98;
        wait_tick(n);
        repeat (10) step();
        period_in = 32'd120;
        wait_tick(m);
        check("midchg_old_cycle", 10 + m, 98);
        check("midchg_period_active", period_active, 120);
        measure(hi, lo, stray);
        check("midchg_new_high", hi, 60);
        check("midchg_new_low", lo, 60);

        // ---- enable low for 20 clks mid-HIGH stretches HIGH ----
        period_in = 32'd98;
        wait_tick(n);
        hi = 0;
        stray = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tone_out !== 1'b1) break;
            hi++;
            if (i > 0 && cycle_tick === 1'b1) stray++;
            if (i == 10) enable = 1'b0;
            if (i == 30) enable = 1'b1;
            step();
        end
        lo = 0;
        while (tone_out === 1'b0 && lo < 1000) begin
            lo++;
            step();
        end
        check("freeze_high", hi, 69);
        check("freeze_low", lo, 49);
        check("freeze_stray_tick", stray, 0);
        check("freeze_tick_at_rise", cycle_tick, 1);

        // ---- enable low on the boundary clk holds the pending tick ----
        repeat (97) step();
        check("pre_boundary_tone", tone_out, 0);
        enable = 1'b0;
        stray = 0;
        repeat (5) begin
            step();
            if (cycle_tick === 1'b1 || tone_out === 1'b1) stray++;
        end
        check("boundary_frozen", stray, 0);
        enable = 1'b1;
        step();
        check("boundary_resume_tick", cycle_tick, 1);
        check("boundary_resume_tone", tone_out, 1);

        // ---- reset mid-LOW with period 120 ----
        period_in = 32'd120;
        wait_tick(n);
        repeat (70) step();
        check("midlow_tone", tone_out, 0);
        rst_n = 1'b0;
        step();
        check("rst2_tone", tone_out, 0);
        check("rst2_tick", cycle_tick, 0);
        check("rst2_period", period_active, 98);
        check("rst2_phase", phase_o, PH_LOW);
        rst_n = 1'b1;
`ifdef FSK_SYMBOL_SEL_EN
        symbol_in = 1'b1;
        period_alt_in = 32'd110;
`endif
        wait_tick(n);
        check("rst2_first_low", n, 49);
`ifdef FSK_SYMBOL_SEL_EN
        check("sym_period_active", period_active, 110);
        measure(hi, lo, stray);
        check("sym_high", hi, 55);
        check("sym_low", lo, 55);
        symbol_in = 1'b0;
`else
        check("rst2_period_after", period_active, 120);
        measure(hi, lo, stray);
        check("rst2_high", hi, 60);
        check("rst2_low", lo, 60);
`endif

        // ---- upper clamp on the full 32-bit request ----
        period_in = 32'h0001_0000;
        wait_tick(n);
        check("clamp_hi_10000", period_active, 65535);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        period_in = 32'hFFFF_FFFF;
        wait_tick(n);
        check("clamp_hi_ffffffff", period_active, 65535);
        check("clamp_hi_tone", tone_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
